spi_reg_ctrl: RTL and testbench
===============================

// Module: spi_reg_ctrl
// PURPOSE
//  SPI (mode 0, write-only) slave that configures the output/PWM peripheral of the top-level user project.
//  Decodes 16-bit frames from the external SPI master and commits them to a small register file.
//  The register file drives the output-enable, PWM-enable and duty-cycle controls of the PWM datapath.
//  Sits between ui_in SPI pins and the PWM block, inside the top-level user project.
// PARAMETERS
//  MAX_ADDR    7'h04  highest valid register address; writes above are dropped
//  SYNC_STAGES 2      synchronizer depth for sclk/copi/ncs (>=2)
// PORTS
//  clk              in   1  system clock; all logic on rising edge
//  rst_n            in   1  synchronous reset, active low
//  sclk             in   1  SPI clock, asynchronous to clk
//  copi             in   1  SPI data in, MSB first, sampled on sclk rising edge
//  ncs              in   1  SPI chip select, active low
//  en_reg_out_7_0   out  8  reg 0x00: output enable uo_out[7:0]
//  en_reg_out_15_8  out  8  reg 0x01: output enable uio_out[7:0]
//  en_reg_pwm_7_0   out  8  reg 0x02: PWM mode select uo_out[7:0]
//  en_reg_pwm_15_8  out  8  reg 0x03: PWM mode select uio_out[7:0]
//  pwm_duty_cycle   out  8  reg 0x04: duty cycle, 0x00=0%, 0xFF=100%
//  wr_strobe        out  1  1-cycle pulse when a register is committed
//  frame_err        out  1  1-cycle pulse on aborted or oversized frame
// BEHAVIOUR
//  - Reset (rst_n low at clk edge): all five registers 8'h00, strobes 0, FSM IDLE, bit counter 0.
//  - Synchronization: sclk, copi and ncs each pass through SYNC_STAGES flops.
//    sclk rise = sync_sclk & ~sclk_q. ncs edges are detected the same way.
//  - Frame: 16 bits. [15] R/W (1=write), [14:8] address, [7:0] data.
//  - FSM:
//    IDLE   -> SHIFT on ncs falling edge; clears shift reg and counter.
//    SHIFT  -> each sclk rise: shift_reg <= {shift_reg[14:0], copi}; cnt++ (5-bit, saturates at 17).
//    SHIFT  -> COMMIT on ncs rising edge with cnt==16.
//    SHIFT  -> IDLE on ncs rising edge with cnt!=16; pulse frame_err.
//    COMMIT -> IDLE after exactly one cycle.
//  - COMMIT: if R/W==1 and addr<=MAX_ADDR, write data to reg[addr] and pulse wr_strobe in the same cycle.
//    Register outputs update on the clk edge ending COMMIT.
//    Read frames (R/W==0) and out-of-range addresses: no write, no error.
//  - cnt>16 at ncs rise: frame_err pulse, no write.
//  - sclk edges while ncs high are ignored. ncs falling edge while in COMMIT is honoured next cycle (IDLE->SHIFT).
//  - Simultaneous sclk rise and ncs rise: shift first, then evaluate cnt.
//  - Reset mid-frame: frame discarded, registers cleared, FSM IDLE.
//  - Latency: ncs rise (pin) -> register updated within SYNC_STAGES+2 clk cycles.
//  - Timing: clk >= 4x sclk frequency.
//  - Outputs are registered only; no combinational path from pins to outputs.
// STRUCTURE
//  - Package spi_reg_pkg: ADDR_EN_OUT_LO..ADDR_DUTY localparams (0x00-0x04), FRAME_BITS=16, FSM state enum.
//  - Sub-module spi_sync_edge: N-stage synchronizer + rise/fall detect.
//    One instance each for sclk and ncs; copi uses the plain synchronized value.
//  - Top: FSM, 16-bit shift reg, counter, register file.
// TESTING
//  - Reset: hold rst_n=0 for 5 clk -> all regs 0x00, wr_strobe=0, frame_err=0.
//  - Write 0x80F0 (addr 0, data 0xF0) -> en_reg_out_7_0=0xF0, one wr_strobe pulse, other regs unchanged.
//  - Write 0x8480 (addr 4) -> pwm_duty_cycle=0x80.
//    Then write 0x8AFF (addr 0x0A) -> no change, no wr_strobe, no frame_err.
//  - Read frame 0x0055 -> no register change. Then an 8-bit frame 0x83 -> frame_err pulse, regs unchanged.
//  - 17-bit frame -> frame_err pulse, no write.
//  - Back-to-back writes (0x8101, then 0x8202 with 1 sclk gap) -> both commit.
//  - rst_n low mid-frame -> regs 0x00; next valid frame commits.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI register controller.
// Register map, frame size and counter limits live here.
package spi_reg_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  localparam int FRAME_BITS = 16;

  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_SAT  = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one async pin, with rise/fall pulses
// derived from the synchronized value and its one-cycle-delayed copy.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Write-only SPI mode-0 slave: decodes 16-bit frames and commits
// them into the five-entry PWM/output-enable register file.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter logic [6:0] MAX_ADDR    = 7'h04,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  logic sclk_s;
  logic sclk_rise;
  logic sclk_fall;
  logic ncs_s;
  logic ncs_rise;
  logic ncs_fall;

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sclk),
    .q     (sclk_s),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_ncs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ncs),
    .q     (ncs_s),
    .rise  (ncs_rise),
    .fall  (ncs_fall)
  );

  logic sclk_unused;
  assign sclk_unused = sclk_s ^ sclk_fall;

  logic [SYNC_STAGES-1:0] copi_q;
  logic [SYNC_STAGES-1:0] copi_d;
  logic                   copi_s;

  assign copi_s = copi_q[SYNC_STAGES-1];

  state_e                  state_q;
  state_e                  state_d;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [FRAME_BITS-1:0]   shift_d;
  logic [4:0]              cnt_q;
  logic [4:0]              cnt_d;
  logic                    pend_q;
  logic                    pend_d;
  logic                    wr_q;
  logic                    wr_d;
  logic                    err_q;
  logic                    err_d;
  logic [7:0]              out_lo_q;
  logic [7:0]              out_lo_d;
  logic [7:0]              out_hi_q;
  logic [7:0]              out_hi_d;
  logic [7:0]              pwm_lo_q;
  logic [7:0]              pwm_lo_d;
  logic [7:0]              pwm_hi_q;
  logic [7:0]              pwm_hi_d;
  logic [7:0]              duty_q;
  logic [7:0]              duty_d;

  logic       frm_wr;
  logic [6:0] frm_addr;
  logic [7:0] frm_data;
  logic       addr_ok;

  assign frm_wr   = shift_q[15];
  assign frm_addr = shift_q[14:8];
  assign frm_data = shift_q[7:0];
  assign addr_ok  = (frm_addr <= MAX_ADDR) &&
                    (frm_addr <= ADDR_DUTY);

  always_comb begin
    copi_d   = {copi_q[SYNC_STAGES-2:0], copi};
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    pend_d   = 1'b0;
    wr_d     = 1'b0;
    err_d    = 1'b0;
    out_lo_d = out_lo_q;
    out_hi_d = out_hi_q;
    pwm_lo_d = pwm_lo_q;
    pwm_hi_d = pwm_hi_q;
    duty_d   = duty_q;

    unique case (state_q)
      ST_IDLE: begin
        // A select that fell during COMMIT starts the frame now.
        if (ncs_fall || (pend_q && !ncs_s)) begin
          state_d = ST_SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        if (ncs_rise) begin
          if (cnt_d == CNT_FULL) begin
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        pend_d  = ncs_fall;
        if (frm_wr && addr_ok) begin
          wr_d = 1'b1;
          unique case (1'b1)
            (frm_addr == ADDR_EN_OUT_LO): out_lo_d = frm_data;
            (frm_addr == ADDR_EN_OUT_HI): out_hi_d = frm_data;
            (frm_addr == ADDR_EN_PWM_LO): pwm_lo_d = frm_data;
            (frm_addr == ADDR_EN_PWM_HI): pwm_hi_d = frm_data;
            (frm_addr == ADDR_DUTY):      duty_d   = frm_data;
            default: wr_d = 1'b0;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      copi_q   <= '0;
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      out_lo_q <= '0;
      out_hi_q <= '0;
      pwm_lo_q <= '0;
      pwm_hi_q <= '0;
      duty_q   <= '0;
    end else begin
      copi_q   <= copi_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      out_lo_q <= out_lo_d;
      out_hi_q <= out_hi_d;
      pwm_lo_q <= pwm_lo_d;
      pwm_hi_q <= pwm_hi_d;
      duty_q   <= duty_d;
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign wr_strobe       = wr_q;
  assign frame_err       = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed plus randomized frames against a register-map model;
// pulses are counted and registers compared after every frame.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int err_cnt  = 0;
  int exp_wr   = 0;
  int exp_err  = 0;
  logic [7:0] m [5];

  always #5 clk = ~clk;

  spi_reg_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_strobe       (wr_strobe),
    .frame_err       (frame_err)
  );

  always @(posedge clk) begin
    if (wr_strobe === 1'b1) wr_cnt <= wr_cnt + 1;
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master side: n bits of f, MSB first; optionally raise ncs
  // together with the last sclk rising edge.
  task automatic send_frame(input logic [16:0] f,
                            input int n,
                            input bit simul);
    logic [16:0] v;
    v = f;
    ncs = 1'b0;
    wait_n(4);
    for (int i = n - 1; i >= 0; i--) begin
      copi = v[i];
      wait_n(4);
      sclk = 1'b1;
      if (simul && i == 0) ncs = 1'b1;
      wait_n(4);
      sclk = 1'b0;
    end
    if (!simul) begin
      wait_n(4);
      ncs = 1'b1;
    end
  endtask

  function automatic void model(input logic [16:0] f, input int n);
    logic [6:0] a;
    a = f[14:8];
    if (n == 16) begin
      if (f[15] && a <= 7'd4) begin
        m[a[2:0]] = f[7:0];
        exp_wr++;
      end
    end else begin
      exp_err++;
    end
  endfunction

  task automatic check_all(input string tag);
    wait_n(12);
    chk({tag, ":out_lo"}, {24'd0, en_reg_out_7_0}, {24'd0, m[0]});
    chk({tag, ":out_hi"}, {24'd0, en_reg_out_15_8}, {24'd0, m[1]});
    chk({tag, ":pwm_lo"}, {24'd0, en_reg_pwm_7_0}, {24'd0, m[2]});
    chk({tag, ":pwm_hi"}, {24'd0, en_reg_pwm_15_8}, {24'd0, m[3]});
    chk({tag, ":duty"}, {24'd0, pwm_duty_cycle}, {24'd0, m[4]});
    chk({tag, ":wr_cnt"}, wr_cnt, exp_wr);
    chk({tag, ":err_cnt"}, err_cnt, exp_err);
  endtask

  task automatic do_frame(input string tag,
                          input logic [16:0] f,
                          input int n);
    send_frame(f, n, 1'b0);
    model(f, n);
    check_all(tag);
  endtask

  initial begin
    logic [16:0] f;
    int n;
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    wait_n(5);
    chk("rst:wr_strobe", {31'd0, wr_strobe}, 32'd0);
    chk("rst:frame_err", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    check_all("reset");

    send_frame(17'h080F0, 16, 1'b0);
    model(17'h080F0, 16);
    repeat (4) @(posedge clk);
    #1;
    chk("latency", {24'd0, en_reg_out_7_0}, 32'hF0);
    check_all("wr_addr0");

    do_frame("wr_addr4", 17'h08480, 16);
    do_frame("wr_addr0a", 17'h08AFF, 16);
    do_frame("read", 17'h00055, 16);
    do_frame("short8", 17'h00083, 8);
    do_frame("long17", 17'h180AA, 17);

    send_frame(17'h08101, 16, 1'b0);
    model(17'h08101, 16);
    wait_n(8);
    send_frame(17'h08202, 16, 1'b0);
    model(17'h08202, 16);
    check_all("b2b");

    send_frame(17'h08333, 16, 1'b1);
    model(17'h08333, 16);
    check_all("simul");

    for (int i = 0; i < 8; i++) begin
      copi = 1'b1;
      wait_n(4);
      sclk = ~sclk;
    end
    sclk = 1'b0;
    do_frame("idle_sclk", 17'h08044, 16);

    ncs = 1'b0;
    wait_n(4);
    for (int i = 0; i < 8; i++) begin
      copi = i[0];
      wait_n(4);
      sclk = 1'b1;
      wait_n(4);
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    ncs   = 1'b1;
    wait_n(5);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    check_all("mid_rst");
    do_frame("post_rst", 17'h08199, 16);

    for (int k = 0; k < 40; k++) begin
      f = 17'($urandom);
      f[14:8] = 7'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0: n = 15;
        1: n = 17;
        2: n = $urandom_range(1, 14);
        default: n = 16;
      endcase
      do_frame("rand", f, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
